// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage sub-word data memory:
// access size codes, controller state encoding and the byte-enable helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2
    } dmem_state_t;

    // Byte enables for an access of the given size starting at lane.
    // Misaligned halves are masked by the error decode, not here.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_subword_ctrl_if.sv
// Request/response bundle between the pipeline MEM stage (master)
// and the sub-word data memory (slave).
interface dmem_subword_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store-data replication, byte enables,
// load extraction with sign/zero extension, and access error decode.
module dmem_lane_fmt
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_rep,
    output logic [3:0]  be,
    output logic [31:0] ld_data,
    output logic        err
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Error decode: illegal size, misalignment, or word index past the array.
    always_comb begin
        err = 1'b0;
        if (size == 2'd3)
            err = 1'b1;
        else if (size == SZ_HALF && addr[0])
            err = 1'b1;
        else if (size == SZ_WORD && addr[1:0] != 2'b00)
            err = 1'b1;
        if (addr[31:2] >= 30'(DEPTH))
            err = 1'b1;
    end

    // Replicate right-aligned store data across every lane it could land in.
    always_comb begin
        be = lane_mask(size, addr[1:0]);
        case (size)
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    // Pick the addressed lane(s) of the read word and extend to 32 bits.
    always_comb begin
        case (addr[1:0])
            2'd0:    ld_byte = rword[7:0];
            2'd1:    ld_byte = rword[15:8];
            2'd2:    ld_byte = rword[23:16];
            default: ld_byte = rword[31:24];
        endcase
        ld_half = addr[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: ld_data = {{24{sgn & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{sgn & ld_half[15]}}, ld_half};
            default: ld_data = rword;
        endcase
    end

endmodule

// File: rtl/dmem_subword_ctrl.sv
// Handshaked byte-addressed data memory with programmable wait states.
// Optional build macro DMEM_CLEAR_EN: sweep the array to zero after reset.
//
//  state | meaning
//  IDLE  | ready for a request
//  WAIT  | request latched, counting down wait states, access on zero
//  CLEAR | post-reset zero sweep, one word per cycle (DMEM_CLEAR_EN only)
module dmem_subword_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input logic clock,
    input logic reset,
    dmem_subword_ctrl_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t state, state_nxt;
    logic [3:0]  cnt;
    logic        accept;
    logic        do_access;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_sgn;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH] = '{default: '0};
    logic [AW-1:0] widx;
    logic [31:0] rword;

    logic [31:0] wdata_rep;
    logic [3:0]  be;
    logic [31:0] ld_data;
    logic        fmt_err;
    logic        mem_we;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

`ifdef DMEM_CLEAR_EN
    localparam dmem_state_t RST_STATE = CLEAR;
    logic [AW-1:0] clr_idx;
    logic          clr_we;
`else
    localparam dmem_state_t RST_STATE = IDLE;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.req_valid;
                if (bus.req_valid)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
`ifdef DMEM_CLEAR_EN
                if (clr_idx == AW'(DEPTH - 1))
                    state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // Wait-state down-counter, loaded on accept.
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= 4'd0;
        else if (accept)
            cnt <= 4'(WAIT_CYCLES);
        else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    // Capture the request; inputs are ignored outside IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_sgn   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= bus.req_we;
            lat_size  <= bus.req_size;
            lat_sgn   <= bus.req_signed;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

`ifdef DMEM_CLEAR_EN
    // Sweep index for the post-reset clear; restarts at word 0 on reset.
    always_ff @(posedge clock) begin
        if (reset)
            clr_idx <= '0;
        else if (state == CLEAR)
            clr_idx <= clr_idx + AW'(1);
    end
    assign clr_we = (state == CLEAR) && !reset;
`endif

    assign widx  = lat_addr[AW+1:2];
    assign rword = mem[widx];

    dmem_lane_fmt #(.DEPTH(DEPTH)) u_fmt (
        .size      (lat_size),
        .sgn       (lat_sgn),
        .addr      (lat_addr),
        .wdata     (lat_wdata),
        .rword     (rword),
        .wdata_rep (wdata_rep),
        .be        (be),
        .ld_data   (ld_data),
        .err       (fmt_err)
    );

    // A reset landing on the access cycle must suppress the write.
    assign mem_we = do_access && lat_we && !fmt_err && !reset;

    // Byte-lane writes for stores, zero writes for the clear sweep.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
`ifdef DMEM_CLEAR_EN
        else if (clr_we) begin
            mem[clr_idx] <= '0;
        end
`endif
    end

    // Response registers: one-cycle valid pulse, data/err held until next response.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= do_access;
            if (do_access) begin
                rsp_err_q   <= fmt_err;
                rsp_rdata_q <= (lat_we || fmt_err) ? 32'd0 : ld_data;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_subword_ctrl.sv
// Bench for dmem_subword_ctrl: two instances (no wait states, DEPTH 64;
// three wait states, DEPTH 16), directed vector table, hand sequences for
// busy/reset corners, and random traffic against a byte-array model.
module tb_dmem_subword_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmem_subword_ctrl_if bus0 ();
    dmem_subword_ctrl_if bus1 ();

    dmem_subword_ctrl #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    dmem_subword_ctrl #(.DEPTH(16), .WAIT_CYCLES(3)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    int          sel = 0;

    assign bus0.req_valid  = req_valid && (sel == 0);
    assign bus1.req_valid  = req_valid && (sel == 1);
    assign bus0.req_we     = req_we;
    assign bus1.req_we     = req_we;
    assign bus0.req_size   = req_size;
    assign bus1.req_size   = req_size;
    assign bus0.req_signed = req_signed;
    assign bus1.req_signed = req_signed;
    assign bus0.req_addr   = req_addr;
    assign bus1.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;
    assign bus1.req_wdata  = req_wdata;

    logic        rdy, rv, rerr;
    logic [31:0] rdat;
    always_comb begin
        rdy  = (sel == 0) ? bus0.req_ready : bus1.req_ready;
        rv   = (sel == 0) ? bus0.rsp_valid : bus1.rsp_valid;
        rerr = (sel == 0) ? bus0.rsp_err   : bus1.rsp_err;
        rdat = (sel == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    end

    int n_total = 0;
    int n_pass  = 0;

    int          dep [2] = '{64, 16};
    int          lat_exp [2] = '{2, 5};
    byte unsigned mb [2][256];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Byte-array reference: a memory of DEPTH*4 bytes, little-endian.
    task automatic model(input int s, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output bit er);
        int     n;
        longint v;
        rd = 0;
        if (size == 2'd3) begin
            er = 1;
            return;
        end
        n  = 1 << size;
        er = (addr % n != 0) || (addr / 4 >= dep[s]);
        if (er) return;
        if (we) begin
            for (int i = 0; i < n; i++) mb[s][addr + i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(mb[s][addr + i]) << (8 * i));
            if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            rd = v[31:0];
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) mb[s][i] = 8'h00;
    endtask

    // One handshaked access; lat counts cycles from accept to rsp_valid (999 = timeout).
    task automatic xact(input int s, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output bit er, output int lat);
        int n;
        sel = s;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rdy && n < 300);
        rd = 0; er = 0; lat = 999;
        if (!rdy) return;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        n = 1;
        while (!rv && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (rv) begin
            lat = n; rd = rdat; er = rerr;
        end
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
`ifdef DMEM_CLEAR_EN
        clear_model();
`endif
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [31:0] rd, mrd;
        bit          er, mer;
        int          lat, n;
        bit          seen;

        vecs.push_back('{1, 2'd2, 0, 32'h08, 32'h12345678, 32'h0,        0});
        vecs.push_back('{0, 2'd2, 0, 32'h08, 32'h0,        32'h12345678, 0});
        vecs.push_back('{1, 2'd0, 0, 32'h09, 32'hAB,       32'h0,        0});
        vecs.push_back('{0, 2'd0, 1, 32'h09, 32'h0,        32'hFFFFFFAB, 0});
        vecs.push_back('{0, 2'd0, 0, 32'h09, 32'h0,        32'h000000AB, 0});
        vecs.push_back('{0, 2'd2, 0, 32'h08, 32'h0,        32'h1234AB78, 0});
        vecs.push_back('{1, 2'd1, 0, 32'h0E, 32'h8001,     32'h0,        0});
        vecs.push_back('{0, 2'd1, 1, 32'h0E, 32'h0,        32'hFFFF8001, 0});
        vecs.push_back('{0, 2'd1, 0, 32'h0E, 32'h0,        32'h00008001, 0});
        vecs.push_back('{0, 2'd1, 1, 32'h0D, 32'h0,        32'h0,        1});
        vecs.push_back('{0, 2'd2, 0, 32'h0C, 32'h0,        32'h80010000, 0});
        vecs.push_back('{1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,       1});
        vecs.push_back('{1, 2'd3, 0, 32'h10, 32'hFFFFFFFF, 32'h0,        1});
        vecs.push_back('{0, 2'd2, 0, 32'h10, 32'h0,        32'h0,        0});
        vecs.push_back('{1, 2'd2, 0, 32'h02, 32'hCAFEF00D, 32'h0,        1});
        vecs.push_back('{0, 2'd2, 0, 32'h00, 32'h0,        32'h0,        0});
        vecs.push_back('{1, 2'd0, 0, 32'h0B, 32'h7F,       32'h0,        0});
        vecs.push_back('{0, 2'd0, 1, 32'h0B, 32'h0,        32'h0000007F, 0});
        vecs.push_back('{0, 2'd2, 0, 32'h08, 32'h0,        32'h7F34AB78, 0});
        vecs.push_back('{0, 2'd1, 1, 32'h08, 32'h0,        32'hFFFFAB78, 0});

        clear_model();

        // Reset values while reset is held, then first cycle after release.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(bus0.rsp_err), 32'd0);
        reset = 1'b0;
        #1;
`ifdef DMEM_CLEAR_EN
        check("rst_ready_clear", 32'(bus0.req_ready), 32'd0);
        n = 0;
        while (bus0.busy && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check("clear_busy_cycles", 32'(n), 32'd64);
`else
        check("rst_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_busy",  32'(bus0.busy), 32'd0);
`endif

        // Directed vectors on the zero-wait instance.
        foreach (vecs[i]) begin
            xact(0, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            model(0, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, mrd, mer);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
        end

        // Wait-state instance: ready low while busy, toggled inputs ignored.
        sel = 1;
        n = 0;
        do begin @(negedge clock); n++; end while (!rdy && n < 300);
        req_we = 1; req_size = 2'd2; req_signed = 0; req_addr = 32'h24; req_wdata = 32'h5A5A1234;
        req_valid = 1'b1;
        model(1, 1, 2'd2, 0, 32'h24, 32'h5A5A1234, mrd, mer);
        @(posedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k < 5) begin
                check($sformatf("ws_ready_T%0d", k), 32'(rdy), 32'd0);
                check($sformatf("ws_rsp_T%0d", k), 32'(rv), 32'd0);
                req_we = 1'($urandom); req_addr = $urandom_range(0, 63) & ~32'h3;
                req_wdata = $urandom; req_size = 2'($urandom);
            end else begin
                req_valid = 1'b0;
                check("ws_rsp_T5", 32'(rv), 32'd1);
                check("ws_ready_T5", 32'(rdy), 32'd1);
                check("ws_err_T5", 32'(rerr), 32'd0);
            end
        end
        @(negedge clock);
        check("ws_rsp_pulse", 32'(rv), 32'd0);
        xact(1, 0, 2'd2, 0, 32'h24, 0, rd, er, lat);
        check("ws_readback", rd, 32'h5A5A1234);
        check("ws_lat", 32'(lat), 32'd5);

        // Reset during WAIT of a store: no response, word unchanged.
        xact(1, 1, 2'd2, 0, 32'h30, 32'h0BADF00D, rd, er, lat);
        model(1, 1, 2'd2, 0, 32'h30, 32'h0BADF00D, mrd, mer);
        n = 0;
        do begin @(negedge clock); n++; end while (!rdy && n < 300);
        req_we = 1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b1;
        seen = 0;
        repeat (2) begin @(negedge clock); seen |= rv; end
        reset = 1'b0;
`ifdef DMEM_CLEAR_EN
        clear_model();
`endif
        repeat (8) begin @(negedge clock); seen |= rv; end
        check("rst_mid_no_rsp", 32'(seen), 32'd0);
        xact(1, 0, 2'd2, 0, 32'h30, 0, rd, er, lat);
        model(1, 0, 2'd2, 0, 32'h30, 0, mrd, mer);
        check("rst_mid_word", rd, mrd);

`ifdef DMEM_CLEAR_EN
        for (int w = 0; w < 16; w++) begin
            xact(1, 0, 2'd2, 0, 32'(4 * w), 0, rd, er, lat);
            check($sformatf("clear_word%0d", w), rd, 32'd0);
        end
`endif

        // Random traffic on both instances against the byte-array model.
        for (int it = 0; it < 300; it++) begin
            int          s;
            bit          we, sg;
            logic [1:0]  sz;
            logic [31:0] ad, wd;
            s  = int'($urandom_range(0, 1));
            we = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = $urandom_range(0, dep[s] * 4 + 15);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                ad = ad & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            xact(s, we, sz, sg, ad, wd, rd, er, lat);
            model(s, we, sz, sg, ad, wd, mrd, mer);
            check($sformatf("rnd%0d_rdata", it), rd, mrd);
            check($sformatf("rnd%0d_err", it), 32'(er), 32'(mer));
            check($sformatf("rnd%0d_lat", it), 32'(lat), 32'(lat_exp[s]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
